// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_seq_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 5;
    localparam int STEP_W = 3;
    localparam int PASS_W = 3;

    localparam logic [STEP_W-1:0] MAX_STEP = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest amount one shifter pass can take out of the remaining total.
    function automatic logic [STEP_W-1:0] step_of(input logic [AMT_W-1:0] rem);
        if (rem > AMT_W'(MAX_STEP)) begin
            return MAX_STEP;
        end
        return rem[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request, result and external barrel-shifter signals of the shift sequencer.
interface shift_seq_if;
    import shift_seq_pkg::*;

    // request side
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  in_amt;
    logic              in_dir;

    // result side
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PASS_W-1:0] out_passes;

    // external 8-bit barrel shifter
    logic [DATA_W-1:0] bs_inp;
    logic [STEP_W-1:0] bs_shamt;
    logic              bs_dir;
    logic [DATA_W-1:0] bs_out;

    // Environment: issues requests, consumes results, provides the shifter.
    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready, bs_out,
        input  in_ready, out_valid, out_data, out_passes, bs_inp, bs_shamt, bs_dir
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready, bs_out,
        output in_ready, out_valid, out_data, out_passes, bs_inp, bs_shamt, bs_dir
    );

endinterface

// File: rtl/shift_seq.sv
// Shift sequencer: composes a 0..31 shift out of chained passes (at most 7
// each) through an external 8-bit barrel shifter, one pass per clock.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    shift_seq_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic [AMT_W-1:0]  rem;
    logic [AMT_W-1:0]  rem_nxt;
    logic              dir;
    logic [PASS_W-1:0] passes;
    logic [STEP_W-1:0] step;
    logic              in_ready;
    logic              out_valid;

    // The per-pass amount depends only on registered state, never on inputs;
    // it is zero whenever no pass is in progress.
    assign step    = (state == SHIFT) ? step_of(rem) : '0;
    assign rem_nxt = rem - AMT_W'(step);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = (bus.in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/amount capture on acceptance and per-pass accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            rem    <= '0;
            dir    <= 1'b0;
            passes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc    <= bus.in_data;
                        rem    <= bus.in_amt;
                        dir    <= bus.in_dir;
                        passes <= '0;
                    end
                end
                SHIFT: begin
                    acc    <= bus.bs_out;
                    rem    <= rem_nxt;
                    passes <= passes + PASS_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = acc;
    assign bus.out_passes = passes;
    assign bus.bs_inp     = acc;
    assign bus.bs_shamt   = step;
    assign bus.bs_dir     = dir;

endmodule

// File: tb/tb_shift_seq.sv
// Directed + random bench for shift_seq with an 8-bit rotator as the shifter.
module tb_shift_seq;
    import shift_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    shift_seq_if bus ();

    shift_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Rotate an 8-bit value by k positions: left when right==0, else right.
    function automatic logic [7:0] rot(input logic [7:0] d, input int k, input logic right);
        logic [7:0] r;
        int s;
        s = right ? (8 - (k % 8)) % 8 : (k % 8);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[(i + s) % 8] = d[i];
        end
        return r;
    endfunction

    assign bus.bs_out = rot(bus.bs_inp, int'(bus.bs_shamt), bus.bs_dir);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),   1);
        check({tag, "_out_valid"},  32'(bus.out_valid),  0);
        check({tag, "_out_data"},   32'(bus.out_data),   0);
        check({tag, "_out_passes"}, 32'(bus.out_passes), 0);
        check({tag, "_bs_inp"},     32'(bus.bs_inp),     0);
        check({tag, "_bs_shamt"},   32'(bus.bs_shamt),   0);
        check({tag, "_bs_dir"},     32'(bus.bs_dir),     0);
    endtask

    // Present a request while idle; returns just after the acceptance edge.
    task automatic issue(input logic [7:0] d, input logic [4:0] a, input logic dr);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dr;
        check("in_ready_idle", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
    endtask

    // Follow an accepted request to its result and complete the handshake.
    // hold: cycles out_ready stays low; poke: offer a stray request meanwhile;
    // chain: keep in_valid high with the next request (nd/na/ndr) presented.
    task automatic collect(input logic [7:0] d, input logic [4:0] a, input logic dr,
                           input int hold, input bit poke, input bit chain,
                           input logic [7:0] nd, input logic [4:0] na, input logic ndr);
        int          lat;
        int          exp_lat;
        int          rest;
        int          n;
        logic [2:0]  seen[$];
        logic [2:0]  want[$];
        logic [7:0]  exp_data;
        logic [2:0]  exp_passes;

        if (chain) begin
            bus.in_valid = 1'b1;
            bus.in_data  = nd;
            bus.in_amt   = na;
            bus.in_dir   = ndr;
        end else begin
            bus.in_valid = 1'b0;
        end

        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            seen.push_back(bus.bs_shamt);
            check("in_ready_busy", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end

        rest = int'(a);
        while (rest > 0) begin
            n = (rest > 7) ? 7 : rest;
            want.push_back(3'(n));
            rest -= n;
        end
        exp_lat    = (a == 0) ? 1 : (int'(a) + 6) / 7 + 1;
        exp_data   = rot(d, int'(a), dr);
        exp_passes = 3'(want.size());

        check("latency", 32'(lat), 32'(exp_lat));
        check("pass_seq_len", 32'(seen.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < seen.size(); i++) begin
            check("bs_shamt_seq", 32'(seen[i]), 32'(want[i]));
        end
        check("out_data", 32'(bus.out_data), 32'(exp_data));
        check("out_passes", 32'(bus.out_passes), 32'(exp_passes));
        check("done_bs_shamt", 32'(bus.bs_shamt), 0);
        check("done_bs_inp", 32'(bus.bs_inp), 32'(exp_data));
        check("done_bs_dir", 32'(bus.bs_dir), 32'(dr));
        check("done_in_ready", 32'(bus.in_ready), 0);

        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (poke && !chain) begin
                bus.in_valid = 1'b1;
                bus.in_data  = ~d;
                bus.in_amt   = a + 5'd1;
                bus.in_dir   = ~dr;
            end
            @(posedge clk); #1;
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_out_data", 32'(bus.out_data), 32'(exp_data));
            check("hold_out_passes", 32'(bus.out_passes), 32'(exp_passes));
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        if (poke && !chain) begin
            bus.in_valid = 1'b0;
        end

        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", 32'(bus.out_valid), 0);
        check("post_hs_in_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset_out_valid", 32'(bus.out_valid), 0);

        // Scenario 1: 0x81 rotl 9 -> 0x03, passes 7,2
        issue(8'h81, 5'd9, 1'b0);
        collect(8'h81, 5'd9, 1'b0, 0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
        check("s1_const_result", 32'(rot(8'h81, 9, 1'b0)), 32'h03);

        // Scenario 2: 0xF0 rotr 31 -> 0xE1, passes 7,7,7,7,3
        issue(8'hF0, 5'd31, 1'b1);
        collect(8'hF0, 5'd31, 1'b1, 1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);

        // Scenario 3: zero amount goes straight to the result
        issue(8'h5A, 5'd0, 1'b0);
        collect(8'h5A, 5'd0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);

        // Scenario 4: consumer stalls 4 cycles while a stray request is offered
        issue(8'h3C, 5'd12, 1'b0);
        collect(8'h3C, 5'd12, 1'b0, 4, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0);
        @(posedge clk); #1;
        check("s4_stray_ignored_in_ready", 32'(bus.in_ready), 1);
        check("s4_stray_ignored_out_valid", 32'(bus.out_valid), 0);

        // Scenario 5: reset during the second pass of the 0xF0/31 request
        issue(8'hF0, 5'd31, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("s5_second_pass_shamt", 32'(bus.bs_shamt), 7);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s5_idle_out_valid", 32'(bus.out_valid), 0);
        issue(8'h81, 5'd9, 1'b0);
        collect(8'h81, 5'd9, 1'b0, 0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);

        // Scenario 6: back-to-back with in_valid held high throughout
        issue(8'hA5, 5'd14, 1'b1);
        collect(8'hA5, 5'd14, 1'b1, 2, 1'b0, 1'b1, 8'h81, 5'd9, 1'b0);
        issue(8'h81, 5'd9, 1'b0);
        collect(8'h81, 5'd9, 1'b0, 0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);

        // Random requests against the rotate-by-total model
        for (int t = 0; t < 25; t++) begin
            logic [7:0] rd;
            logic [4:0] ra;
            logic       rdir;
            int         rh;
            rd   = 8'($urandom);
            ra   = 5'($urandom_range(0, 31));
            rdir = 1'($urandom);
            rh   = int'($urandom_range(0, 3));
            issue(rd, ra, rdir);
            collect(rd, ra, rdir, rh, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: none; widths are fixed (data 8, request amount 5, pass amount 3).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  shift request present.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 in_data  in  8  operand.
REQ-008 in_amt  in  5  total shift amount, 0..31.
REQ-009 in_dir  in  1  direction, passed unchanged to the shifter.
REQ-010 bs_inp  out  8  operand to the 8-bit barrel shifter.
REQ-011 bs_shamt  out  3  per-pass amount to the barrel shifter.
REQ-012 bs_dir  out  1  direction to the barrel shifter.
REQ-013 bs_out  in  8  combinational result from the barrel shifter.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 out_data  out  8  final result.
REQ-017 out_passes  out  3  number of shifter passes used, 0..5.

Function
REQ-018 The block SHALL run a state machine with states IDLE, SHIFT and DONE.
REQ-019 IDLE: in_ready=1 and out_valid=0. When in_valid=1, the block SHALL latch acc<=in_data, rem<=in_amt, dir<=in_dir and passes<=0.
REQ-020 From IDLE on acceptance, the next state SHALL be DONE if in_amt==0, otherwise SHIFT.
REQ-021 SHIFT: bs_inp=acc, bs_shamt=min(rem,7) and bs_dir=dir, all driven from registers only. Each cycle the block SHALL set acc<=bs_out, rem<=rem-bs_shamt and passes<=passes+1.
REQ-022 The state SHALL move from SHIFT to DONE in the cycle where rem-bs_shamt==0. The pass count is therefore ceil(in_amt/7) cycles.
REQ-023 DONE: out_valid=1, out_data=acc, out_passes=passes. On out_ready=1 the state SHALL return to IDLE.
REQ-024 Latency from the acceptance edge to out_valid SHALL be ceil(in_amt/7)+1 cycles, and 1 cycle when in_amt==0.
REQ-025 in_ready SHALL be 0 in SHIFT and DONE. There is no overlap: the next request is accepted no earlier than the cycle after the DONE handshake.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_passes SHALL hold stable.
REQ-027 Outside SHIFT, bs_shamt SHALL be 0, bs_inp=acc and bs_dir=dir.
REQ-028 The block SHALL be agnostic to the shifter's semantics (rotate or logical). The shift is composed purely by chaining passes.
REQ-029 All subtraction on rem SHALL be 5-bit and never underflow. Because step=min(rem,7), rem reaches exactly 0.

Reset
REQ-030 On rst_n=0 at any time, including mid-SHIFT, the block SHALL asynchronously enter IDLE with acc=0, rem=0, dir=0 and passes=0.
REQ-031 Output reset values SHALL be: in_ready=1, out_valid=0, out_data=0, out_passes=0, bs_inp=0, bs_shamt=0, bs_dir=0.
REQ-032 Any in-flight request SHALL be discarded on reset, and no partial result SHALL appear on the outputs.

Structure
REQ-033 The shared package shift_seq_pkg SHALL hold the state encoding (IDLE/SHIFT/DONE), MAX_STEP=7, and the width constants DATA_W=8, AMT_W=5, STEP_W=3.
REQ-034 The barrel shifter SHALL be instantiated outside this block. The bench and top level connect bs_* to it.
REQ-035 No sub-module is required. The step computation min(rem,7) may be a function in shift_seq_pkg.

Verification
REQ-036 The bench SHALL model bs_out as an 8-bit rotator: dir=0 rotates left, dir=1 rotates right.
REQ-037 Scenario 1: in_data=0x81, in_amt=9, dir=0 -> bs_shamt sequence 7,2; out_data=0x03; out_passes=2; out_valid 3 cycles after acceptance.
REQ-038 Scenario 2: in_data=0xF0, in_amt=31, dir=1 -> bs_shamt sequence 7,7,7,7,3; out_data=0xE1; out_passes=5; latency 6 cycles.
REQ-039 Scenario 3: in_data=0x5A, in_amt=0 -> no SHIFT cycle; out_data=0x5A; out_passes=0; out_valid 1 cycle after acceptance.
REQ-040 Scenario 4: complete a request with out_ready held 0 for 4 cycles -> out_data and out_passes stable, in_ready=0, and a new in_valid is ignored until the DONE handshake.
REQ-041 Scenario 5: assert rst_n=0 during the second pass of Scenario 2 -> immediate IDLE with all outputs at reset values; a subsequent 0x81/9 request yields 0x03.
REQ-042 Scenario 6: issue back-to-back requests with in_valid held 1 -> the second request is accepted in the cycle after the first DONE handshake, and its result is correct.
